// File: rtl/cxl_arb_pkg.sv
// Shared definitions for the CXL AXI arbiter: AXI encodings, the index-width helper and the grant FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cxl_arb_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_e;

    // Width of a requester index. It is never zero, so a single requester still gets one ID bit.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cxl_arb_rr.sv
// Round-robin picker with a two-state grant FSM. It is used for both the AW channel and the AR channel.
// Latency: the grant is visible one cycle after a request is sampled in IDLE, and one bubble cycle separates grants.
// Backpressure: the grant holds until out_ready. start_ok=0 blocks only new grants.
// Ports: clock, reset_n (sync, active-low); req_valid/req_ready per requester;
//        start_ok gates IDLE->GRANT; out_valid/out_ready form the downstream handshake; winner is the granted index.
module cxl_arb_rr
    import cxl_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               start_ok,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [IDX_W-1:0]   winner,
    output logic [NUM_REQ-1:0] req_ready
);

    arb_state_e       state, state_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_nxt;
    logic [IDX_W-1:0] win_q, win_nxt;
    logic [IDX_W-1:0] pick;
    logic [IDX_W:0]   cand;
    logic             found;

    assign winner = win_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= ARB_IDLE;
            rr_ptr <= '0;
            win_q  <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_nxt;
            win_q  <= win_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        win_nxt   = win_q;
        out_valid = 1'b0;
        req_ready = '0;
        pick      = rr_ptr;
        cand      = '0;
        found     = 1'b0;

        // Search starts at rr_ptr and wraps modulo NUM_REQ. The first valid requester wins.
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!found && req_valid[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDX_W-1:0];
            end
        end

        case (state)
            ARB_IDLE: begin
                if (start_ok && found) begin
                    state_nxt = ARB_GRANT;
                    win_nxt   = pick;
                end
            end
            ARB_GRANT: begin
                out_valid        = 1'b1;
                req_ready[win_q] = out_ready;
                if (out_ready) begin
                    state_nxt = ARB_IDLE;
                    if (int'(win_q) == NUM_REQ - 1) begin
                        rr_nxt = '0;
                    end else begin
                        rr_nxt = win_q + 1'b1;
                    end
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

endmodule

// File: rtl/cxl_axi_arbiter.sv
// Lets NUM_REQ AXI4 requesters share one CXL memory slave port. AW and AR each have a round-robin arbiter.
// W data follows an in-order grant FIFO. B and R are routed by the requester index carried in the top bits of the ID.
// Latency: 1 cycle request->cxl valid on AW/AR. W, B and R are combinational pass-through.
// Backpressure: AW stalls while the grant FIFO is full. W, B and R ready come straight from the selected peer.
// Ports: clock, reset_n (sync, active-low); req_* are packed per requester (slice i = requester i);
//        cxl_* is the master side toward the CXL IP; cxl_link_up is the link status.
// Optional feature: define CXL_ARB_LINK_GATE_EN to hold off new AW/AR grants while cxl_link_up=0.
module cxl_axi_arbiter
    import cxl_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 64,
    parameter int REQ_ID_WIDTH = 2,
    parameter int WFIFO_DEPTH  = 4
) (
    input  logic                                        clock,
    input  logic                                        reset_n,
    // requester AW
    input  logic [NUM_REQ-1:0]                          req_aw_valid,
    output logic [NUM_REQ-1:0]                          req_aw_ready,
    input  logic [NUM_REQ*REQ_ID_WIDTH-1:0]             req_aw_id,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]               req_aw_addr,
    input  logic [NUM_REQ*8-1:0]                        req_aw_len,
    // requester W
    input  logic [NUM_REQ-1:0]                          req_w_valid,
    output logic [NUM_REQ-1:0]                          req_w_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]               req_w_data,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]           req_w_strb,
    input  logic [NUM_REQ-1:0]                          req_w_last,
    // requester B
    output logic [NUM_REQ-1:0]                          req_b_valid,
    input  logic [NUM_REQ-1:0]                          req_b_ready,
    output logic [REQ_ID_WIDTH-1:0]                     req_b_id,
    output logic [1:0]                                  req_b_resp,
    // requester AR
    input  logic [NUM_REQ-1:0]                          req_ar_valid,
    output logic [NUM_REQ-1:0]                          req_ar_ready,
    input  logic [NUM_REQ*REQ_ID_WIDTH-1:0]             req_ar_id,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]               req_ar_addr,
    input  logic [NUM_REQ*8-1:0]                        req_ar_len,
    // requester R
    output logic [NUM_REQ-1:0]                          req_r_valid,
    input  logic [NUM_REQ-1:0]                          req_r_ready,
    output logic [REQ_ID_WIDTH-1:0]                     req_r_id,
    output logic [DATA_WIDTH-1:0]                       req_r_data,
    output logic [1:0]                                  req_r_resp,
    output logic                                        req_r_last,
    // CXL AW
    output logic                                        cxl_awvalid,
    input  logic                                        cxl_awready,
    output logic [REQ_ID_WIDTH+idx_width(NUM_REQ)-1:0]  cxl_awid,
    output logic [ADDR_WIDTH-1:0]                       cxl_awaddr,
    output logic [7:0]                                  cxl_awlen,
    output logic [2:0]                                  cxl_awsize,
    output logic [1:0]                                  cxl_awburst,
    output logic [2:0]                                  cxl_awprot,
    output logic [3:0]                                  cxl_awcache,
    output logic [3:0]                                  cxl_awqos,
    output logic [0:0]                                  cxl_awuser,
    // CXL W
    output logic                                        cxl_wvalid,
    input  logic                                        cxl_wready,
    output logic [DATA_WIDTH-1:0]                       cxl_wdata,
    output logic [DATA_WIDTH/8-1:0]                     cxl_wstrb,
    output logic                                        cxl_wlast,
    // CXL B
    input  logic                                        cxl_bvalid,
    output logic                                        cxl_bready,
    input  logic [REQ_ID_WIDTH+idx_width(NUM_REQ)-1:0]  cxl_bid,
    input  logic [1:0]                                  cxl_bresp,
    // CXL AR
    output logic                                        cxl_arvalid,
    input  logic                                        cxl_arready,
    output logic [REQ_ID_WIDTH+idx_width(NUM_REQ)-1:0]  cxl_arid,
    output logic [ADDR_WIDTH-1:0]                       cxl_araddr,
    output logic [7:0]                                  cxl_arlen,
    output logic [2:0]                                  cxl_arsize,
    output logic [1:0]                                  cxl_arburst,
    output logic [2:0]                                  cxl_arprot,
    output logic [3:0]                                  cxl_arcache,
    output logic [3:0]                                  cxl_arqos,
    output logic [0:0]                                  cxl_aruser,
    // CXL R
    input  logic                                        cxl_rvalid,
    output logic                                        cxl_rready,
    input  logic [REQ_ID_WIDTH+idx_width(NUM_REQ)-1:0]  cxl_rid,
    input  logic [DATA_WIDTH-1:0]                       cxl_rdata,
    input  logic [1:0]                                  cxl_rresp,
    input  logic                                        cxl_rlast,
    // link status
    input  logic                                        cxl_link_up
);

    localparam int IDX_W    = idx_width(NUM_REQ);
    localparam int CXL_ID_W = REQ_ID_WIDTH + IDX_W;
    localparam int PTR_W    = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam logic [2:0] AXI_SIZE = 3'($clog2(STRB_W));

    // ---------------------------------------------------------------- unpack
    logic [REQ_ID_WIDTH-1:0] aw_id_a   [NUM_REQ];
    logic [ADDR_WIDTH-1:0]   aw_addr_a [NUM_REQ];
    logic [7:0]              aw_len_a  [NUM_REQ];
    logic [REQ_ID_WIDTH-1:0] ar_id_a   [NUM_REQ];
    logic [ADDR_WIDTH-1:0]   ar_addr_a [NUM_REQ];
    logic [7:0]              ar_len_a  [NUM_REQ];
    logic [DATA_WIDTH-1:0]   w_data_a  [NUM_REQ];
    logic [STRB_W-1:0]       w_strb_a  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign aw_id_a[g]   = req_aw_id[g*REQ_ID_WIDTH +: REQ_ID_WIDTH];
        assign aw_addr_a[g] = req_aw_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign aw_len_a[g]  = req_aw_len[g*8 +: 8];
        assign ar_id_a[g]   = req_ar_id[g*REQ_ID_WIDTH +: REQ_ID_WIDTH];
        assign ar_addr_a[g] = req_ar_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign ar_len_a[g]  = req_ar_len[g*8 +: 8];
        assign w_data_a[g]  = req_w_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign w_strb_a[g]  = req_w_strb[g*STRB_W +: STRB_W];
    end

    // ---------------------------------------------------------------- link gate
    logic link_ok;
`ifdef CXL_ARB_LINK_GATE_EN
    assign link_ok = cxl_link_up;
`else
    logic unused_link_up;
    assign unused_link_up = cxl_link_up;
    assign link_ok        = 1'b1;
`endif

    // ---------------------------------------------------------------- W grant FIFO
    logic [IDX_W-1:0] wq_mem [WFIFO_DEPTH];
    logic [PTR_W-1:0] wq_wr, wq_rd;
    logic [PTR_W:0]   wq_cnt;
    logic             wq_full, wq_empty, wq_push, wq_pop;
    logic [IDX_W-1:0] aw_win, ar_win, w_head;

    assign wq_full  = (wq_cnt == (PTR_W+1)'(WFIFO_DEPTH));
    assign wq_empty = (wq_cnt == '0);
    assign wq_push  = cxl_awvalid && cxl_awready;
    assign wq_pop   = cxl_wvalid && cxl_wready && cxl_wlast;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wq_wr  <= '0;
            wq_rd  <= '0;
            wq_cnt <= '0;
        end else begin
            if (wq_push) begin
                wq_mem[wq_wr] <= aw_win;
                wq_wr         <= wq_wr + 1'b1;
            end
            if (wq_pop) begin
                wq_rd <= wq_rd + 1'b1;
            end
            // A push cannot happen while the FIFO is full because the AW grant is gated on !wq_full.
            case ({wq_push, wq_pop})
                2'b10:   wq_cnt <= wq_cnt + 1'b1;
                2'b01:   wq_cnt <= wq_cnt - 1'b1;
                default: wq_cnt <= wq_cnt;
            endcase
        end
    end

    // ---------------------------------------------------------------- AW / AR arbiters
    cxl_arb_rr #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_aw_rr (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_aw_valid),
        .start_ok  (!wq_full && link_ok),
        .out_ready (cxl_awready),
        .out_valid (cxl_awvalid),
        .winner    (aw_win),
        .req_ready (req_aw_ready)
    );

    cxl_arb_rr #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_ar_rr (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_ar_valid),
        .start_ok  (link_ok),
        .out_ready (cxl_arready),
        .out_valid (cxl_arvalid),
        .winner    (ar_win),
        .req_ready (req_ar_ready)
    );

    assign cxl_awid    = {aw_win, aw_id_a[aw_win]};
    assign cxl_awaddr  = aw_addr_a[aw_win];
    assign cxl_awlen   = aw_len_a[aw_win];
    assign cxl_awsize  = AXI_SIZE;
    assign cxl_awburst = AXI_BURST_INCR;
    assign cxl_awprot  = '0;
    assign cxl_awcache = '0;
    assign cxl_awqos   = '0;
    assign cxl_awuser  = '0;

    assign cxl_arid    = {ar_win, ar_id_a[ar_win]};
    assign cxl_araddr  = ar_addr_a[ar_win];
    assign cxl_arlen   = ar_len_a[ar_win];
    assign cxl_arsize  = AXI_SIZE;
    assign cxl_arburst = AXI_BURST_INCR;
    assign cxl_arprot  = '0;
    assign cxl_arcache = '0;
    assign cxl_arqos   = '0;
    assign cxl_aruser  = '0;

    // ---------------------------------------------------------------- W steering
    assign w_head     = wq_mem[wq_rd];
    assign cxl_wvalid = !wq_empty && req_w_valid[w_head];
    assign cxl_wdata  = w_data_a[w_head];
    assign cxl_wstrb  = w_strb_a[w_head];
    assign cxl_wlast  = req_w_last[w_head];

    always_comb begin
        req_w_ready = '0;
        if (!wq_empty) begin
            req_w_ready[w_head] = cxl_wready;
        end
    end

    // ---------------------------------------------------------------- B / R routing
    logic [IDX_W-1:0] b_idx, r_idx;
    assign b_idx = cxl_bid[CXL_ID_W-1 -: IDX_W];
    assign r_idx = cxl_rid[CXL_ID_W-1 -: IDX_W];

    assign req_b_id   = cxl_bid[REQ_ID_WIDTH-1:0];
    assign req_b_resp = cxl_bresp;
    assign req_r_id   = cxl_rid[REQ_ID_WIDTH-1:0];
    assign req_r_data = cxl_rdata;
    assign req_r_resp = cxl_rresp;
    assign req_r_last = cxl_rlast;

    // An index with no requester behind it is accepted and discarded, so the IP never stalls on it.
    always_comb begin
        req_b_valid = '0;
        cxl_bready  = 1'b1;
        if (int'(b_idx) < NUM_REQ) begin
            req_b_valid[b_idx] = cxl_bvalid;
            cxl_bready         = req_b_ready[b_idx];
        end
    end

    always_comb begin
        req_r_valid = '0;
        cxl_rready  = 1'b1;
        if (int'(r_idx) < NUM_REQ) begin
            req_r_valid[r_idx] = cxl_rvalid;
            cxl_rready         = req_r_ready[r_idx];
        end
    end

endmodule

// File: tb/tb_cxl_axi_arbiter.sv
// Directed bench for cxl_axi_arbiter. It covers AR round-robin, W ordering, grant-FIFO full stall,
// B/R routing, link gating and reset in the middle of a burst. Default parameters are used (2 requesters, 3-bit CXL ID).
module tb_cxl_axi_arbiter;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [1:0]   req_aw_valid, req_aw_ready;
    logic [3:0]   req_aw_id;
    logic [127:0] req_aw_addr;
    logic [15:0]  req_aw_len;
    logic [1:0]   req_w_valid, req_w_ready;
    logic [127:0] req_w_data;
    logic [15:0]  req_w_strb;
    logic [1:0]   req_w_last;
    logic [1:0]   req_b_valid, req_b_ready;
    logic [1:0]   req_b_id, req_b_resp;
    logic [1:0]   req_ar_valid, req_ar_ready;
    logic [3:0]   req_ar_id;
    logic [127:0] req_ar_addr;
    logic [15:0]  req_ar_len;
    logic [1:0]   req_r_valid, req_r_ready;
    logic [1:0]   req_r_id, req_r_resp;
    logic [63:0]  req_r_data;
    logic         req_r_last;
    logic         cxl_awvalid, cxl_awready;
    logic [2:0]   cxl_awid;
    logic [63:0]  cxl_awaddr;
    logic [7:0]   cxl_awlen;
    logic [2:0]   cxl_awsize, cxl_awprot;
    logic [1:0]   cxl_awburst;
    logic [3:0]   cxl_awcache, cxl_awqos;
    logic [0:0]   cxl_awuser;
    logic         cxl_wvalid, cxl_wready, cxl_wlast;
    logic [63:0]  cxl_wdata;
    logic [7:0]   cxl_wstrb;
    logic         cxl_bvalid, cxl_bready;
    logic [2:0]   cxl_bid;
    logic [1:0]   cxl_bresp;
    logic         cxl_arvalid, cxl_arready;
    logic [2:0]   cxl_arid;
    logic [63:0]  cxl_araddr;
    logic [7:0]   cxl_arlen;
    logic [2:0]   cxl_arsize, cxl_arprot;
    logic [1:0]   cxl_arburst;
    logic [3:0]   cxl_arcache, cxl_arqos;
    logic [0:0]   cxl_aruser;
    logic         cxl_rvalid, cxl_rready, cxl_rlast;
    logic [2:0]   cxl_rid;
    logic [63:0]  cxl_rdata;
    logic [1:0]   cxl_rresp;
    logic         cxl_link_up;

    int checks = 0;
    int errors = 0;

    cxl_axi_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .req_aw_valid(req_aw_valid), .req_aw_ready(req_aw_ready), .req_aw_id(req_aw_id),
        .req_aw_addr(req_aw_addr), .req_aw_len(req_aw_len),
        .req_w_valid(req_w_valid), .req_w_ready(req_w_ready), .req_w_data(req_w_data),
        .req_w_strb(req_w_strb), .req_w_last(req_w_last),
        .req_b_valid(req_b_valid), .req_b_ready(req_b_ready), .req_b_id(req_b_id), .req_b_resp(req_b_resp),
        .req_ar_valid(req_ar_valid), .req_ar_ready(req_ar_ready), .req_ar_id(req_ar_id),
        .req_ar_addr(req_ar_addr), .req_ar_len(req_ar_len),
        .req_r_valid(req_r_valid), .req_r_ready(req_r_ready), .req_r_id(req_r_id),
        .req_r_data(req_r_data), .req_r_resp(req_r_resp), .req_r_last(req_r_last),
        .cxl_awvalid(cxl_awvalid), .cxl_awready(cxl_awready), .cxl_awid(cxl_awid), .cxl_awaddr(cxl_awaddr),
        .cxl_awlen(cxl_awlen), .cxl_awsize(cxl_awsize), .cxl_awburst(cxl_awburst), .cxl_awprot(cxl_awprot),
        .cxl_awcache(cxl_awcache), .cxl_awqos(cxl_awqos), .cxl_awuser(cxl_awuser),
        .cxl_wvalid(cxl_wvalid), .cxl_wready(cxl_wready), .cxl_wdata(cxl_wdata),
        .cxl_wstrb(cxl_wstrb), .cxl_wlast(cxl_wlast),
        .cxl_bvalid(cxl_bvalid), .cxl_bready(cxl_bready), .cxl_bid(cxl_bid), .cxl_bresp(cxl_bresp),
        .cxl_arvalid(cxl_arvalid), .cxl_arready(cxl_arready), .cxl_arid(cxl_arid), .cxl_araddr(cxl_araddr),
        .cxl_arlen(cxl_arlen), .cxl_arsize(cxl_arsize), .cxl_arburst(cxl_arburst), .cxl_arprot(cxl_arprot),
        .cxl_arcache(cxl_arcache), .cxl_arqos(cxl_arqos), .cxl_aruser(cxl_aruser),
        .cxl_rvalid(cxl_rvalid), .cxl_rready(cxl_rready), .cxl_rid(cxl_rid), .cxl_rdata(cxl_rdata),
        .cxl_rresp(cxl_rresp), .cxl_rlast(cxl_rlast),
        .cxl_link_up(cxl_link_up)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    // Moves to 1 time unit after the next rising edge, where outputs are sampled and inputs are changed.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int hs;
    int beats;

    initial begin
        reset_n = 1'b0;
        req_aw_valid = '0; req_aw_id = '0; req_aw_addr = '0; req_aw_len = '0;
        req_w_valid = '0; req_w_data = '0; req_w_strb = '1; req_w_last = '0;
        req_b_ready = '0; req_ar_valid = '0; req_ar_id = '0; req_ar_addr = '0; req_ar_len = '0;
        req_r_ready = '0;
        cxl_awready = 1'b1; cxl_wready = 1'b1; cxl_arready = 1'b1;
        cxl_bvalid = 1'b0; cxl_bid = '0; cxl_bresp = '0;
        cxl_rvalid = 1'b0; cxl_rid = '0; cxl_rdata = '0; cxl_rresp = '0; cxl_rlast = 1'b0;
        cxl_link_up = 1'b1;
        tick(); tick();

        // ---- reset state
        chk("rst_awvalid", cxl_awvalid, 1'b0);
        chk("rst_arvalid", cxl_arvalid, 1'b0);
        chk("rst_wvalid",  cxl_wvalid,  1'b0);
        chk("rst_aw_rdy",  req_aw_ready, 2'b00);
        chk("rst_ar_rdy",  req_ar_ready, 2'b00);
        chk("rst_w_rdy",   req_w_ready,  2'b00);
        reset_n = 1'b1;
        tick();

        // ---- AR: both requesters in the same cycle, rr_ptr=0
        req_ar_id   = {2'b10, 2'b01};
        req_ar_addr = {64'h2000, 64'h1000};
        req_ar_len  = {8'd7, 8'd1};
        req_ar_valid = 2'b11;
        tick();
        chk("ar0_vld",   cxl_arvalid, 1'b1);
        chk("ar0_id",    cxl_arid, 3'b001);
        chk("ar0_addr",  cxl_araddr, 64'h1000);
        chk("ar0_len",   cxl_arlen, 8'd1);
        chk("ar0_rdy",   req_ar_ready, 2'b01);
        chk("ar_size",   cxl_arsize, 3'd3);
        chk("ar_burst",  cxl_arburst, 2'b01);
        tick();
        req_ar_valid = 2'b10;
        #1;
        chk("ar_bubble", cxl_arvalid, 1'b0);
        tick();
        chk("ar1_vld",   cxl_arvalid, 1'b1);
        chk("ar1_id",    cxl_arid, 3'b110);
        chk("ar1_addr",  cxl_araddr, 64'h2000);
        chk("ar1_rdy",   req_ar_ready, 2'b10);
        tick();
        req_ar_valid = 2'b00;

        // ---- W ordering: req1 AW len=3, then req0 AW len=0
        req_aw_id   = {2'b11, 2'b00};
        req_aw_addr = {64'hB000, 64'hA000};
        req_aw_len  = {8'd3, 8'd0};
        req_aw_valid = 2'b10;
        tick();
        chk("aw1_vld",  cxl_awvalid, 1'b1);
        chk("aw1_id",   cxl_awid, 3'b111);
        chk("aw1_len",  cxl_awlen, 8'd3);
        chk("aw1_rdy",  req_aw_ready, 2'b10);
        chk("aw_size",  cxl_awsize, 3'd3);
        tick();
        req_aw_valid = 2'b01;
        req_w_valid  = 2'b11;
        req_w_data[63:0] = 64'hA0;
        req_w_last[0]    = 1'b1;
        for (int b = 0; b < 4; b++) begin
            if (b == 2) req_aw_valid = 2'b00;
            req_w_data[127:64] = 64'hB0 + 64'(b);
            req_w_last[1]      = (b == 3);
            #1;
            chk("w1_vld",  cxl_wvalid, 1'b1);
            chk("w1_data", cxl_wdata, 64'hB0 + 64'(b));
            chk("w1_last", cxl_wlast, (b == 3));
            chk("w1_rdy",  req_w_ready, 2'b10);
            if (b == 1) chk("aw0_id", cxl_awid, 3'b000);
            tick();
        end
        req_w_valid = 2'b01;
        #1;
        chk("w0_data", cxl_wdata, 64'hA0);
        chk("w0_last", cxl_wlast, 1'b1);
        chk("w0_rdy",  req_w_ready, 2'b01);
        tick();
        req_w_valid = 2'b00;
        #1;
        chk("w_empty", cxl_wvalid, 1'b0);

        // ---- grant FIFO full: 4 AWs accepted with cxl_wready=0, then the 5th is held
        cxl_wready   = 1'b0;
        req_aw_valid = 2'b01;
        hs = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (cxl_awvalid && cxl_awready) hs++;
            tick();
        end
        chk("full_hs",    hs, 4);
        chk("full_awvld", cxl_awvalid, 1'b0);
        chk("full_awrdy", req_aw_ready, 2'b00);
        req_w_valid = 2'b01;
        req_w_last  = 2'b01;
        cxl_wready  = 1'b1;
        beats = 0;
        #1;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) begin
                req_aw_valid = 2'b00;
                #1;
            end
            if (cxl_wvalid && cxl_wready) beats++;
            if (i == 1) chk("pop_awvld0", cxl_awvalid, 1'b0);
            if (i == 2) begin
                chk("pop_awvld1", cxl_awvalid, 1'b1);
                chk("pop_awrdy",  req_aw_ready, 2'b01);
            end
            tick();
        end
        chk("drain_beats", beats, 5);
        chk("drain_empty", cxl_wvalid, 1'b0);
        req_w_valid = 2'b00;
        req_w_last  = 2'b00;

        // ---- B / R routing
        cxl_rvalid = 1'b1; cxl_rid = 3'b110; cxl_rdata = 64'hDEAD; cxl_rresp = 2'b00; cxl_rlast = 1'b1;
        req_r_ready = 2'b01;
        cxl_bvalid = 1'b1; cxl_bid = 3'b001; cxl_bresp = 2'b10;
        req_b_ready = 2'b01;
        #1;
        chk("r_rready0", cxl_rready, 1'b0);
        chk("r_valid",   req_r_valid, 2'b10);
        chk("r_id",      req_r_id, 2'b10);
        chk("r_data",    req_r_data, 64'hDEAD);
        chk("r_last",    req_r_last, 1'b1);
        chk("b_valid",   req_b_valid, 2'b01);
        chk("b_bready",  cxl_bready, 1'b1);
        chk("b_id",      req_b_id, 2'b01);
        chk("b_resp",    req_b_resp, 2'b10);
        req_r_ready = 2'b10;
        #1;
        chk("r_rready1", cxl_rready, 1'b1);
        tick();
        cxl_rvalid = 1'b0; cxl_bvalid = 1'b0;
        req_r_ready = '0; req_b_ready = '0;

        // ---- link status vs AR grant
        cxl_link_up  = 1'b0;
        req_ar_valid = 2'b01;
`ifdef CXL_ARB_LINK_GATE_EN
        tick(); tick();
        chk("link_hold", cxl_arvalid, 1'b0);
        cxl_link_up = 1'b1;
        tick();
        chk("link_go",   cxl_arvalid, 1'b1);
`else
        tick();
        chk("link_ign",  cxl_arvalid, 1'b1);
`endif
        tick();
        req_ar_valid = 2'b00;
        cxl_link_up  = 1'b1;

        // ---- reset in the middle of a W burst (AR rr_ptr is 1 here)
        req_aw_valid = 2'b10;
        tick(); tick();
        req_aw_valid = 2'b00;
        req_w_valid  = 2'b10;
        req_w_last   = 2'b00;
        tick();
        #1;
        chk("mid_wvld", cxl_wvalid, 1'b1);
        reset_n      = 1'b0;
        req_ar_valid = 2'b11;
        tick();
        chk("mrst_wvld",  cxl_wvalid, 1'b0);
        chk("mrst_wrdy",  req_w_ready, 2'b00);
        chk("mrst_awvld", cxl_awvalid, 1'b0);
        chk("mrst_arvld", cxl_arvalid, 1'b0);
        chk("mrst_awrdy", req_aw_ready, 2'b00);
        chk("mrst_arrdy", req_ar_ready, 2'b00);
        reset_n = 1'b1;
        tick();
        chk("post_arid", cxl_arid, 3'b001);
        chk("post_wvld", cxl_wvalid, 1'b0);
        tick();
        req_ar_valid = 2'b00;
        req_w_valid  = 2'b00;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
